// File: rtl/trigger_arm_ctrl.sv
// Arm/capture sequencer for the pulse time-of-flight trigger generator.
// Owns trig_enable, counts shots, captures pulse_tof with valid/ack, enforces re-arm holdoff.
module trigger_arm_ctrl #(
  parameter int unsigned SHOT_W  = 16,
  parameter int unsigned TIMER_W = 32
) (
  input  logic               rxclk,
  input  logic               rst,
  input  logic               sw_arm,
  input  logic               sw_abort,
  input  logic [SHOT_W-1:0]  num_shots,
  input  logic [TIMER_W-1:0] arm_timeout,
  input  logic [TIMER_W-1:0] rearm_holdoff,
  input  logic [7:0]         detect_pls,
  input  logic [31:0]        pulse_tof,
  input  logic               result_ack,
  output logic               trig_enable,
  output logic [31:0]        result_tof,
  output logic               result_valid,
  output logic [SHOT_W-1:0]  shot_count,
  output logic               busy,
  output logic               done,
  output logic               timeout_flag,
  output logic               overrun_flag,
  output logic [2:0]         state_o
);

  localparam int unsigned TOF_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    HOLDOFF = 3'd3,
    DONE    = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic                 trig_enable_q, trig_en_d;
  logic [TOF_W-1:0]     result_tof_q;
  logic                 result_valid_q;
  logic [SHOT_W-1:0]    shot_count_q, shot_inc;
  logic                 busy_q, done_q;
  logic                 timeout_q, overrun_q;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic [SHOT_W-1:0]    cfg_shots_q;
  logic [TIMER_W-1:0]   cfg_timeout_q, cfg_holdoff_q, hold_eff;
  logic                 det_prev_q;
  logic                 fire, arm_ok, timeout_hit, last_shot, hold_end, capture;
  logic                 unused_det;

  assign unused_det = ^{detect_pls[7:5], detect_pls[3:0]};

  // Condition decode shared by next-state and datapath
  always_comb begin
    fire        = detect_pls[4] & ~det_prev_q;
    arm_ok      = sw_arm & ~sw_abort & ((state_q == IDLE) | (state_q == DONE));
    hold_eff    = (cfg_holdoff_q == '0) ? TIMER_W'(1) : cfg_holdoff_q;
    timeout_hit = (cfg_timeout_q != '0) && (timer_q == cfg_timeout_q - TIMER_W'(1));
    shot_inc    = (&shot_count_q) ? shot_count_q : shot_count_q + SHOT_W'(1);
    last_shot   = (cfg_shots_q != '0) && (shot_inc == cfg_shots_q);
    hold_end    = (timer_q == hold_eff - TIMER_W'(1));
    capture     = (state_q == CAPTURE) & ~sw_abort;
  end

  // Next state; abort overrides everything, illegal encodings fall back to IDLE
  always_comb begin
    state_d = state_q;
    if (sw_abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE: if (sw_arm) state_d = ARMED;
        ARMED: begin
          if (fire)             state_d = CAPTURE;
          else if (timeout_hit) state_d = DONE;
        end
        CAPTURE: state_d = last_shot ? DONE : HOLDOFF;
        HOLDOFF: if (hold_end) state_d = ARMED;
        default: state_d = IDLE;
      endcase
    end
  end

  // Shared per-shot timer: ARMED timeout count, then HOLDOFF length
  always_comb begin
    timer_d = '0;
    case (state_q)
      ARMED:   timer_d = timer_q + TIMER_W'(1);
      HOLDOFF: timer_d = hold_end ? '0 : timer_q + TIMER_W'(1);
      default: timer_d = '0;
    endcase
    trig_en_d = (state_d == ARMED) | (state_d == CAPTURE);
  end

  always_ff @(posedge rxclk) begin
    if (rst) begin
      state_q        <= IDLE;
      trig_enable_q  <= 1'b0;
      result_tof_q   <= '0;
      result_valid_q <= 1'b0;
      shot_count_q   <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      timeout_q      <= 1'b0;
      overrun_q      <= 1'b0;
      timer_q        <= '0;
      cfg_shots_q    <= '0;
      cfg_timeout_q  <= '0;
      cfg_holdoff_q  <= '0;
      det_prev_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_enable_q <= trig_en_d;
      busy_q        <= (state_d == ARMED) | (state_d == CAPTURE) | (state_d == HOLDOFF);
      done_q        <= (state_d == DONE);
      timer_q       <= timer_d;
      // Edge history follows the enable being driven so a level held across re-arm is not a new edge
      det_prev_q    <= trig_en_d & detect_pls[4];

      if (arm_ok) begin
        cfg_shots_q   <= num_shots;
        cfg_timeout_q <= arm_timeout;
        cfg_holdoff_q <= rearm_holdoff;
        shot_count_q  <= '0;
        timeout_q     <= 1'b0;
        overrun_q     <= 1'b0;
      end

      if ((state_q == ARMED) && !sw_abort && !fire && timeout_hit) timeout_q <= 1'b1;

      if (capture) begin
        result_tof_q   <= pulse_tof;
        result_valid_q <= 1'b1;
        shot_count_q   <= shot_inc;
        if (result_valid_q && !result_ack) overrun_q <= 1'b1;
      end else if (result_valid_q && result_ack) begin
        result_valid_q <= 1'b0;
      end
    end
  end

  assign trig_enable  = trig_enable_q;
  assign result_tof   = result_tof_q;
  assign result_valid = result_valid_q;
  assign shot_count   = shot_count_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign timeout_flag = timeout_q;
  assign overrun_flag = overrun_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_trigger_arm_ctrl.sv
// Directed bench for trigger_arm_ctrl: shots, holdoff, timeout, handshake, abort, reset.
module tb_trigger_arm_ctrl;

  logic        rxclk = 1'b0;
  logic        rst;
  logic        sw_arm, sw_abort;
  logic [15:0] num_shots;
  logic [31:0] arm_timeout, rearm_holdoff;
  logic [7:0]  detect_pls;
  logic [31:0] pulse_tof;
  logic        result_ack;
  logic        trig_enable;
  logic [31:0] result_tof;
  logic        result_valid;
  logic [15:0] shot_count;
  logic        busy, done, timeout_flag, overrun_flag;
  logic [2:0]  state_o;

  int vectors = 0;
  int miscompares = 0;

  trigger_arm_ctrl #(.SHOT_W(16), .TIMER_W(32)) dut (
    .rxclk(rxclk), .rst(rst), .sw_arm(sw_arm), .sw_abort(sw_abort),
    .num_shots(num_shots), .arm_timeout(arm_timeout), .rearm_holdoff(rearm_holdoff),
    .detect_pls(detect_pls), .pulse_tof(pulse_tof), .result_ack(result_ack),
    .trig_enable(trig_enable), .result_tof(result_tof), .result_valid(result_valid),
    .shot_count(shot_count), .busy(busy), .done(done), .timeout_flag(timeout_flag),
    .overrun_flag(overrun_flag), .state_o(state_o)
  );

  always #4 rxclk = ~rxclk;

  task automatic tick();
    @(posedge rxclk);
    #1;
  endtask

  // Arm, then scramble the live config so only the shadowed copy can be in effect
  task automatic arm_pulse(input logic [15:0] shots, input logic [31:0] tmo, input logic [31:0] hold);
    num_shots = shots; arm_timeout = tmo; rearm_holdoff = hold;
    sw_arm = 1'b1;
    tick();
    sw_arm = 1'b0;
    num_shots = ~shots; arm_timeout = ~tmo; rearm_holdoff = ~hold;
  endtask

  // Rising edge of detect_pls[4] in the current cycle; returns two cycles later
  task automatic fire_shot(input logic [31:0] tof);
    detect_pls[4] = 1'b1; pulse_tof = tof;
    tick();
    detect_pls[4] = 1'b0;
    tick();
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    vectors++;
    if ({trig_enable, result_valid, busy, done, timeout_flag, overrun_flag} !== 6'b0 ||
        result_tof !== 32'h0 || shot_count !== 16'h0 || state_o !== 3'd0) begin
      $display("FAIL reset: te=%b rv=%b busy=%b done=%b to=%b ov=%b tof=%h sc=%0d st=%0d, want all 0",
               trig_enable, result_valid, busy, done, timeout_flag, overrun_flag, result_tof, shot_count, state_o);
      miscompares++;
    end
  endtask

  task automatic test_single_shot();
    arm_pulse(16'd1, 32'd0, 32'd3);
    vectors++;
    if ({state_o, trig_enable, busy, done} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL single_armed: st=%0d te=%b busy=%b done=%b, want 1 1 1 0", state_o, trig_enable, busy, done);
      miscompares++;
    end
    repeat (99) tick();
    detect_pls[4] = 1'b1; pulse_tof = 32'h1234;
    tick();
    vectors++;
    if ({state_o, trig_enable, result_valid} !== {3'd2, 1'b1, 1'b0}) begin
      $display("FAIL single_n1: st=%0d te=%b rv=%b, want 2 1 0", state_o, trig_enable, result_valid);
      miscompares++;
    end
    tick();
    detect_pls[4] = 1'b0;
    vectors++;
    if (result_tof !== 32'h1234 || {result_valid, done, trig_enable, busy} !== 4'b1100 ||
        shot_count !== 16'd1 || state_o !== 3'd4) begin
      $display("FAIL single_n2: tof=%h rv=%b done=%b te=%b busy=%b sc=%0d st=%0d, want 1234 1 1 0 0 1 4",
               result_tof, result_valid, done, trig_enable, busy, shot_count, state_o);
      miscompares++;
    end
    ack_result();
    vectors++;
    if (result_valid !== 1'b0) begin
      $display("FAIL ack_clear: rv=%b, want 0", result_valid);
      miscompares++;
    end
  endtask

  task automatic test_multi_shot(input logic [31:0] hold, input int exp_low);
    int cnt;
    arm_pulse(16'd3, 32'd0, hold);
    for (int s = 1; s <= 3; s++) begin
      repeat (3) tick();
      fire_shot(32'h100 + 32'(s));
      vectors++;
      if (shot_count !== 16'(s) || result_tof !== 32'h100 + 32'(s)) begin
        $display("FAIL multi_shot%0d: sc=%0d tof=%h, want %0d %h", s, shot_count, result_tof, s, 32'h100 + 32'(s));
        miscompares++;
      end
      if (s < 3) begin
        cnt = 0;
        result_ack = 1'b1;
        while (trig_enable === 1'b0 && cnt < 40) begin
          cnt++;
          tick();
          result_ack = 1'b0;
        end
        vectors++;
        if (cnt !== exp_low || state_o !== 3'd1) begin
          $display("FAIL holdoff_len%0d: low=%0d st=%0d, want %0d 1", s, cnt, state_o, exp_low);
          miscompares++;
        end
      end
    end
    vectors++;
    if ({state_o, done, trig_enable, overrun_flag} !== {3'd4, 1'b1, 1'b0, 1'b0}) begin
      $display("FAIL multi_done: st=%0d done=%b te=%b ov=%b, want 4 1 0 0", state_o, done, trig_enable, overrun_flag);
      miscompares++;
    end
    ack_result();
  endtask

  task automatic test_timeout();
    arm_pulse(16'd1, 32'd50, 32'd1);
    repeat (49) tick();
    vectors++;
    if (state_o !== 3'd1 || timeout_flag !== 1'b0) begin
      $display("FAIL timeout_early: st=%0d to=%b, want 1 0", state_o, timeout_flag);
      miscompares++;
    end
    tick();
    vectors++;
    if ({state_o, timeout_flag, done, trig_enable} !== {3'd4, 1'b1, 1'b1, 1'b0}) begin
      $display("FAIL timeout_hit: st=%0d to=%b done=%b te=%b, want 4 1 1 0", state_o, timeout_flag, done, trig_enable);
      miscompares++;
    end
    arm_pulse(16'd1, 32'd50, 32'd1);
    vectors++;
    if (timeout_flag !== 1'b0 || state_o !== 3'd1) begin
      $display("FAIL timeout_rearm: to=%b st=%0d, want 0 1", timeout_flag, state_o);
      miscompares++;
    end
    repeat (49) tick();
    detect_pls[4] = 1'b1; pulse_tof = 32'h5050;
    tick();
    detect_pls[4] = 1'b0;
    vectors++;
    if (state_o !== 3'd2 || timeout_flag !== 1'b0) begin
      $display("FAIL fire_beats_timeout: st=%0d to=%b, want 2 0", state_o, timeout_flag);
      miscompares++;
    end
    tick();
    vectors++;
    if (state_o !== 3'd4 || shot_count !== 16'd1 || timeout_flag !== 1'b0 || result_tof !== 32'h5050) begin
      $display("FAIL fire_done: st=%0d sc=%0d to=%b tof=%h, want 4 1 0 5050", state_o, shot_count, timeout_flag, result_tof);
      miscompares++;
    end
    ack_result();
  endtask

  task automatic test_overrun();
    arm_pulse(16'd2, 32'd0, 32'd1);
    fire_shot(32'hAAAA_0001);
    tick();
    fire_shot(32'hBBBB_0002);
    vectors++;
    if ({overrun_flag, result_valid, state_o} !== {1'b1, 1'b1, 3'd4} || result_tof !== 32'hBBBB_0002) begin
      $display("FAIL overrun: ov=%b rv=%b st=%0d tof=%h, want 1 1 4 bbbb0002", overrun_flag, result_valid, state_o, result_tof);
      miscompares++;
    end
    ack_result();
    arm_pulse(16'd2, 32'd0, 32'd1);
    vectors++;
    if (overrun_flag !== 1'b0) begin
      $display("FAIL overrun_clear: ov=%b, want 0", overrun_flag);
      miscompares++;
    end
    fire_shot(32'hCCCC_0003);
    tick();
    detect_pls[4] = 1'b1; pulse_tof = 32'hDDDD_0004;
    tick();
    detect_pls[4] = 1'b0;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    vectors++;
    if ({overrun_flag, result_valid, state_o} !== {1'b0, 1'b1, 3'd4} || result_tof !== 32'hDDDD_0004) begin
      $display("FAIL ack_with_capture: ov=%b rv=%b st=%0d tof=%h, want 0 1 4 dddd0004", overrun_flag, result_valid, state_o, result_tof);
      miscompares++;
    end
    ack_result();
  endtask

  task automatic test_abort();
    arm_pulse(16'd0, 32'd0, 32'd10);
    fire_shot(32'h0000_0011);
    repeat (10) tick();
    vectors++;
    if (state_o !== 3'd1 || trig_enable !== 1'b1) begin
      $display("FAIL cont_rearm: st=%0d te=%b, want 1 1", state_o, trig_enable);
      miscompares++;
    end
    fire_shot(32'h0000_0022);
    tick();
    vectors++;
    if (state_o !== 3'd3 || shot_count !== 16'd2) begin
      $display("FAIL cont_holdoff: st=%0d sc=%0d, want 3 2", state_o, shot_count);
      miscompares++;
    end
    sw_abort = 1'b1;
    tick();
    sw_abort = 1'b0;
    vectors++;
    if ({state_o, trig_enable, busy, done, result_valid} !== {3'd0, 1'b0, 1'b0, 1'b0, 1'b1} ||
        shot_count !== 16'd2 || result_tof !== 32'h22) begin
      $display("FAIL abort: st=%0d te=%b busy=%b done=%b rv=%b sc=%0d tof=%h, want 0 0 0 0 1 2 22",
               state_o, trig_enable, busy, done, result_valid, shot_count, result_tof);
      miscompares++;
    end
    sw_arm = 1'b1; sw_abort = 1'b1;
    tick();
    sw_arm = 1'b0; sw_abort = 1'b0;
    tick();
    vectors++;
    if (state_o !== 3'd0 || trig_enable !== 1'b0 || shot_count !== 16'd2) begin
      $display("FAIL arm_abort: st=%0d te=%b sc=%0d, want 0 0 2", state_o, trig_enable, shot_count);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_and_level();
    arm_pulse(16'd1, 32'd0, 32'd1);
    repeat (4) tick();
    vectors++;
    if (state_o !== 3'd1 || result_valid !== 1'b1) begin
      $display("FAIL pre_reset: st=%0d rv=%b, want 1 1", state_o, result_valid);
      miscompares++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if ({trig_enable, result_valid, busy, done, timeout_flag, overrun_flag} !== 6'b0 ||
        result_tof !== 32'h0 || shot_count !== 16'h0 || state_o !== 3'd0) begin
      $display("FAIL reset_mid: te=%b rv=%b busy=%b done=%b to=%b ov=%b tof=%h sc=%0d st=%0d, want all 0",
               trig_enable, result_valid, busy, done, timeout_flag, overrun_flag, result_tof, shot_count, state_o);
      miscompares++;
    end
    detect_pls[4] = 1'b1; pulse_tof = 32'hBAD0_BAD0;
    tick();
    arm_pulse(16'd1, 32'd20, 32'd1);
    repeat (10) tick();
    vectors++;
    if (state_o !== 3'd1 || result_valid !== 1'b0 || shot_count !== 16'd0) begin
      $display("FAIL level_held: st=%0d rv=%b sc=%0d, want 1 0 0", state_o, result_valid, shot_count);
      miscompares++;
    end
    detect_pls[4] = 1'b0;
    tick();
    fire_shot(32'hBEEF);
    vectors++;
    if (state_o !== 3'd4 || result_tof !== 32'hBEEF || shot_count !== 16'd1) begin
      $display("FAIL level_then_edge: st=%0d tof=%h sc=%0d, want 4 beef 1", state_o, result_tof, shot_count);
      miscompares++;
    end
  endtask

  initial begin
    rst = 1'b1; sw_arm = 1'b0; sw_abort = 1'b0; result_ack = 1'b0;
    num_shots = '0; arm_timeout = '0; rearm_holdoff = '0;
    detect_pls = 8'h00; pulse_tof = '0;
    test_reset();
    test_single_shot();
    test_multi_shot(32'd5, 5);
    test_multi_shot(32'd0, 1);
    test_timeout();
    test_overrun();
    test_abort();
    test_reset_mid_and_level();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
